// File: rtl/bsg_manycore_remote_arb_pkg.sv
// Shared types and constants for the manycore remote request arbiter.
package bsg_manycore_remote_arb_pkg;

    localparam int unsigned remote_addr_bit_gp = 31;

    typedef enum logic {
        eIDLE,
        eLOCKED
    } arb_state_e;

    // Address and op header of one request; data and mask are carried alongside at data_width_p.
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic        swap_aq;
        logic        swap_rl;
    } remote_req_s;

endpackage

// File: rtl/bsg_manycore_rr_grant.sv
// Pointer-based round-robin arbiter: one-hot grant of the first eligible requester at or after ptr.
module bsg_manycore_rr_grant #(
    parameter int unsigned num_req_p = 2,
    localparam int unsigned id_width_lp = $clog2(num_req_p)
) (
    input  logic [num_req_p-1:0]   eligible_i,
    input  logic [id_width_lp-1:0] ptr_i,
    output logic [num_req_p-1:0]   grant_o,
    output logic [id_width_lp-1:0] grant_id_o,
    output logic                   v_o
);

    int unsigned idx;

    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        v_o        = 1'b0;
        idx        = 0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            idx = (int'(ptr_i) + i) % num_req_p;
            if (!v_o && eligible_i[idx]) begin
                grant_o[idx] = 1'b1;
                grant_id_o   = id_width_lp'(idx);
                v_o          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_manycore_remote_req_arbiter.sv
// Round-robin arbiter sharing one remote-packet encode path, with credits and a swap lock.
// Optional per-requester grant and credit-stall counters under BSG_MANYCORE_REMOTE_ARB_STATS_EN.
module bsg_manycore_remote_req_arbiter
    import bsg_manycore_remote_arb_pkg::*;
#(
    parameter int unsigned num_req_p = 2,
    parameter int unsigned data_width_p = 32,
    parameter int unsigned max_out_credits_p = 16,
    localparam int unsigned mask_width_lp = data_width_p >> 3,
    localparam int unsigned credit_width_lp = $clog2(max_out_credits_p + 1),
    localparam int unsigned id_width_lp = $clog2(num_req_p)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p*32-1:0]           req_addr_i,
    input  logic [num_req_p*data_width_p-1:0] req_data_i,
    input  logic [num_req_p*mask_width_lp-1:0] req_mask_i,
    input  logic [num_req_p-1:0]              req_we_i,
    input  logic [num_req_p-1:0]              req_swap_aq_i,
    input  logic [num_req_p-1:0]              req_swap_rl_i,
    output logic [num_req_p-1:0]              req_yumi_o,
    output logic                              out_v_o,
    output logic [31:0]                       out_addr_o,
    output logic [data_width_p-1:0]           out_data_o,
    output logic [mask_width_lp-1:0]          out_mask_o,
    output logic                              out_we_o,
    output logic                              out_swap_aq_o,
    output logic                              out_swap_rl_o,
    output logic [id_width_lp-1:0]            out_src_id_o,
    input  logic                              out_ready_i,
    input  logic                              credit_return_i,
    output logic [credit_width_lp-1:0]        out_credits_o,
    output logic                              lock_v_o
`ifdef BSG_MANYCORE_REMOTE_ARB_STATS_EN
    ,
    output logic [num_req_p*32-1:0]           stat_grants_o,
    output logic [31:0]                       stat_stall_o
`endif
);

    localparam logic [credit_width_lp-1:0] credit_max_lp = credit_width_lp'(max_out_credits_p);

    arb_state_e                 state_q;
    logic [id_width_lp-1:0]     lock_id_q, ptr_q, ptr_next;
    logic [credit_width_lp-1:0] credits_q;

    logic                       out_v_q;
    remote_req_s                out_hdr_q, sel_hdr;
    logic [data_width_p-1:0]    out_data_q, sel_data;
    logic [mask_width_lp-1:0]   out_mask_q, sel_mask;
    logic [id_width_lp-1:0]     out_src_q;

    logic [num_req_p-1:0]       lock_mask, eligible, grant;
    logic [id_width_lp-1:0]     grant_id;
    logic                       grant_v, load;

    always_comb begin
        lock_mask            = '0;
        lock_mask[lock_id_q] = 1'b1;
        eligible             = (state_q == eLOCKED) ? (req_v_i & lock_mask) : req_v_i;
    end

    bsg_manycore_rr_grant #(
        .num_req_p (num_req_p)
    ) u_rr_grant (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .grant_o    (grant),
        .grant_id_o (grant_id),
        .v_o        (grant_v)
    );

    // Credit gating uses only the registered count, so a same-cycle return cannot enable a grant.
    assign load       = reset_n_i && (!out_v_q || out_ready_i) && (credits_q != '0) && grant_v;
    assign req_yumi_o = load ? grant : '0;
    assign ptr_next   = (grant_id == id_width_lp'(num_req_p - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        sel_hdr.addr    = req_addr_i[grant_id*32 +: 32];
        sel_hdr.we      = req_we_i[grant_id];
        sel_hdr.swap_aq = req_swap_aq_i[grant_id];
        sel_hdr.swap_rl = req_swap_rl_i[grant_id];
        sel_data        = req_data_i[grant_id*data_width_p +: data_width_p];
        sel_mask        = req_mask_i[grant_id*mask_width_lp +: mask_width_lp];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            out_v_q    <= 1'b0;
            out_hdr_q  <= '0;
            out_data_q <= '0;
            out_mask_q <= '0;
            out_src_q  <= '0;
        end else if (load) begin
            out_v_q    <= 1'b1;
            out_hdr_q  <= sel_hdr;
            out_data_q <= sel_data;
            out_mask_q <= sel_mask;
            out_src_q  <= grant_id;
        end else if (out_ready_i) begin
            out_v_q    <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= eIDLE;
            lock_id_q <= '0;
            ptr_q     <= '0;
            credits_q <= credit_max_lp;
        end else begin
            if (load) begin
                ptr_q <= ptr_next;
                // Acquire takes priority over release when both arrive together.
                if (sel_hdr.swap_aq) begin
                    state_q   <= eLOCKED;
                    lock_id_q <= grant_id;
                end else if (state_q == eLOCKED && sel_hdr.swap_rl) begin
                    state_q <= eIDLE;
                end
            end
            case ({load, credit_return_i})
                2'b10:   credits_q <= credits_q - 1'b1;
                2'b01:   if (credits_q != credit_max_lp) credits_q <= credits_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            if (credit_return_i && !load && credits_q == credit_max_lp)
                $error("credit return with all credits available");
            if (load && sel_hdr.swap_aq && sel_hdr.swap_rl)
                $error("request carries both swap_aq and swap_rl");
            if (load && !sel_hdr.addr[remote_addr_bit_gp] && (sel_hdr.swap_aq || sel_hdr.swap_rl))
                $error("swap op on a non-remote address");
        end
    end

    assign out_v_o       = out_v_q;
    assign out_addr_o    = out_hdr_q.addr;
    assign out_data_o    = out_data_q;
    assign out_mask_o    = out_mask_q;
    assign out_we_o      = out_hdr_q.we;
    assign out_swap_aq_o = out_hdr_q.swap_aq;
    assign out_swap_rl_o = out_hdr_q.swap_rl;
    assign out_src_id_o  = out_src_q;
    assign out_credits_o = credits_q;
    assign lock_v_o      = (state_q == eLOCKED);

`ifdef BSG_MANYCORE_REMOTE_ARB_STATS_EN
    logic [num_req_p*32-1:0] grants_q;
    logic [31:0]             stall_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            grants_q <= '0;
            stall_q  <= '0;
        end else begin
            for (int i = 0; i < num_req_p; i++) begin
                if (req_yumi_o[i]) grants_q[i*32 +: 32] <= grants_q[i*32 +: 32] + 32'd1;
            end
            if (|req_v_i && !load && credits_q == '0) stall_q <= stall_q + 32'd1;
        end
    end

    assign stat_grants_o = grants_q;
    assign stat_stall_o  = stall_q;
`endif

endmodule

// File: tb/tb_bsg_manycore_remote_req_arbiter.sv
// Directed bench for the remote request arbiter: round-robin, credits, swap lock, back-pressure, reset.
module tb_bsg_manycore_remote_req_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_v, req_we, req_aq, req_rl, yumi;
    logic [63:0] req_addr, req_data;
    logic [7:0]  req_mask;
    logic        out_v, out_we, out_aq, out_rl, out_src, out_ready, credit_ret, lock_v;
    logic [31:0] out_addr, out_data;
    logic [3:0]  out_mask;
    logic [4:0]  credits;
`ifdef BSG_MANYCORE_REMOTE_ARB_STATS_EN
    logic [63:0] stat_grants;
    logic [31:0] stat_stall;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    bsg_manycore_remote_req_arbiter #(
        .num_req_p         (2),
        .data_width_p      (32),
        .max_out_credits_p (16)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .req_v_i         (req_v),
        .req_addr_i      (req_addr),
        .req_data_i      (req_data),
        .req_mask_i      (req_mask),
        .req_we_i        (req_we),
        .req_swap_aq_i   (req_aq),
        .req_swap_rl_i   (req_rl),
        .req_yumi_o      (yumi),
        .out_v_o         (out_v),
        .out_addr_o      (out_addr),
        .out_data_o      (out_data),
        .out_mask_o      (out_mask),
        .out_we_o        (out_we),
        .out_swap_aq_o   (out_aq),
        .out_swap_rl_o   (out_rl),
        .out_src_id_o    (out_src),
        .out_ready_i     (out_ready),
        .credit_return_i (credit_ret),
        .out_credits_o   (credits),
        .lock_v_o        (lock_v)
`ifdef BSG_MANYCORE_REMOTE_ARB_STATS_EN
        ,
        .stat_grants_o   (stat_grants),
        .stat_stall_o    (stat_stall)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        req_v      = 2'b11;
        req_we     = 2'b10;
        req_aq     = 2'b00;
        req_rl     = 2'b00;
        req_addr   = {32'h8000_0004, 32'h8000_0000};
        req_data   = {32'h2222_2222, 32'h1111_1111};
        req_mask   = {4'h3, 4'hf};
        out_ready  = 1'b1;
        credit_ret = 1'b0;

        // Reset state, with requests already pending
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_v", out_v, 0);
        chk("rst_yumi", yumi, 0);
        chk("rst_credits", credits, 16);
        chk("rst_lock", lock_v, 0);
        chk("rst_addr", out_addr, 0);
        reset_n = 1'b1;
        #1;

        // Round-robin with both requesters valid until credits run out
        for (int k = 0; k < 16; k++) begin
            chk("rr_yumi", yumi, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k == 0) chk("rr_first_out_v", out_v, 0);
            tick();
            chk("rr_out_v", out_v, 1);
            chk("rr_src", out_src, k % 2);
            if (k == 1) begin
                chk("rr_addr1", out_addr, 32'h8000_0004);
                chk("rr_data1", out_data, 32'h2222_2222);
                chk("rr_mask1", out_mask, 4'h3);
                chk("rr_we1", out_we, 1);
            end
        end
        chk("cred_empty", credits, 0);
        chk("cred_empty_yumi", yumi, 0);

        // Single credit return yields exactly one grant
        credit_ret = 1'b1;
        #1;
        chk("ret_same_cycle_yumi", yumi, 0);
        tick();
        credit_ret = 1'b0;
        #1;
        chk("ret_credits_1", credits, 1);
        chk("ret_yumi", yumi, 2'b01);
        tick();
        chk("ret_credits_0", credits, 0);
        chk("ret_src", out_src, 0);
        chk("ret_yumi_stop", yumi, 0);

        // Simultaneous yumi and return at 5 credits
        req_v      = 2'b00;
        credit_ret = 1'b1;
        repeat (5) tick();
        req_v = 2'b01;
        #1;
        chk("sim_credits_5", credits, 5);
        chk("sim_yumi", yumi, 2'b01);
        tick();
        chk("sim_credits_hold", credits, 5);
        req_v = 2'b00;
        repeat (11) tick();
        credit_ret = 1'b0;
        #1;
        chk("refill_credits", credits, 16);

        // Swap lock starves requester 1 until requester 0 releases
        req_addr[31:0] = 32'h8000_0100;
        req_aq         = 2'b01;
        req_v          = 2'b01;
        #1;
        chk("aq_yumi", yumi, 2'b01);
        tick();
        req_aq = 2'b00;
        req_v  = 2'b10;
        #1;
        chk("aq_lock", lock_v, 1);
        chk("aq_out_aq", out_aq, 1);
        chk("aq_out_addr", out_addr, 32'h8000_0100);
        chk("lock_starve", yumi, 0);
        repeat (3) begin
            tick();
            chk("lock_starve_hold", yumi, 0);
            chk("lock_hold", lock_v, 1);
        end
        req_v  = 2'b11;
        req_rl = 2'b01;
        #1;
        chk("rl_yumi", yumi, 2'b01);
        tick();
        req_rl = 2'b00;
        #1;
        chk("rl_unlock", lock_v, 0);
        chk("rl_out_rl", out_rl, 1);
        chk("post_rl_yumi", yumi, 2'b10);
        tick();
        chk("post_rl_credits", credits, 13);

        // Back-pressure holds the entry and blocks grants
        out_ready = 1'b0;
        #1;
        repeat (5) begin
            chk("bp_yumi", yumi, 0);
            chk("bp_out_v", out_v, 1);
            chk("bp_src", out_src, 1);
            chk("bp_addr", out_addr, 32'h8000_0004);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_yumi", yumi, 2'b01);
        tick();
        chk("bp_reload_src", out_src, 0);
        chk("bp_reload_addr", out_addr, 32'h8000_0100);

        // Reset in the middle of a lock with a held entry
        req_aq = 2'b01;
        req_v  = 2'b01;
        #1;
        chk("rst2_aq_yumi", yumi, 2'b01);
        tick();
        out_ready = 1'b0;
        #1;
        chk("rst2_pre_lock", lock_v, 1);
        chk("rst2_pre_out_v", out_v, 1);
        reset_n = 1'b0;
        #1;
        chk("rst2_out_v", out_v, 0);
        chk("rst2_lock", lock_v, 0);
        chk("rst2_credits", credits, 16);
        chk("rst2_yumi", yumi, 0);
        reset_n   = 1'b1;
        req_aq    = 2'b00;
        req_v     = 2'b11;
        out_ready = 1'b1;
        #1;
        chk("rst2_ptr_yumi", yumi, 2'b01);
        tick();
        chk("rst2_src", out_src, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
